guess: RTL and testbench

GUESS -- requirements
Module: guess

---
 rtl/guess.sv | 61 ++++++
 tb/tb_guess.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/guess.sv
// Four-digit guess entry: a 2-bit cursor selects one of four 3-bit digits that
// the up/down buttons step modulo 8; left/right move the cursor modulo 4.
module guess (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  output logic [2:0] led_zero,
  output logic [2:0] led_one,
  output logic [2:0] led_two,
  output logic [2:0] led_three,
  output logic [1:0] sel_led
);

  logic [1:0]      sel_q, sel_d;
  logic [3:0][2:0] digit_q, digit_d;

  always_comb begin
    sel_d = sel_q;
    if (enable) begin
      if (right && !left) begin
        sel_d = sel_q + 2'd1;
      end else if (left && !right) begin
        sel_d = sel_q - 2'd1;
      end
    end
  end

  // The digit step is addressed by the pre-edge cursor, so a simultaneous
  // move and step edits the old digit and shows the new cursor next cycle.
  always_comb begin
    digit_d = digit_q;
    if (enable) begin
      if (up && !down) begin
        digit_d[sel_q] = digit_q[sel_q] + 3'd1;
      end else if (down && !up) begin
        digit_d[sel_q] = digit_q[sel_q] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= 2'd0;
      digit_q <= '0;
    end else begin
      sel_q   <= sel_d;
      digit_q <= digit_d;
    end
  end

  assign sel_led   = sel_q;
  assign led_zero  = digit_q[0];
  assign led_one   = digit_q[1];
  assign led_two   = digit_q[2];
  assign led_three = digit_q[3];

endmodule

// File: tb/tb_guess.sv
// Directed bench for guess: each task drives one scenario and checks the
// registered outputs one clock after the sampling edge against hand values.
module tb_guess;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [2:0] led_zero, led_one, led_two, led_three;
  logic [1:0] sel_led;

  int errors = 0;
  int checks = 0;

  guess dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .left      (left),
    .right     (right),
    .up        (up),
    .down      (down),
    .led_zero  (led_zero),
    .led_one   (led_one),
    .led_two   (led_two),
    .led_three (led_three),
    .sel_led   (sel_led)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle, then wait past the edge so outputs are settled.
  task automatic step(input logic r, input logic e, input logic l, input logic rt,
                      input logic u, input logic d);
    rst = r; enable = e; left = l; right = rt; up = u; down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({led_three, led_two, led_one, led_zero, sel_led} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0000", {led_three, led_two, led_one, led_zero, sel_led});
    end else $display("ok reset_state");
  endtask

  task automatic test_up_run;
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (led_zero !== 3'(i % 8)) begin
        errors++;
        $display("FAIL up_run[%0d]: led_zero got %0d expected %0d", i, led_zero, i % 8);
      end else $display("ok up_run[%0d] led_zero=%0d", i, led_zero);
    end
    checks++;
    if ({led_three, led_two, led_one, sel_led} !== 11'd0) begin
      errors++;
      $display("FAIL up_run_others: got %h expected 000", {led_three, led_two, led_one, sel_led});
    end else $display("ok up_run_others");
  endtask

  task automatic test_sel_wrap;
    logic [1:0] exp_sel [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else       step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (sel_led !== exp_sel[i]) begin
        errors++;
        $display("FAIL sel_wrap[%0d]: sel_led got %0d expected %0d", i, sel_led, exp_sel[i]);
      end else $display("ok sel_wrap[%0d] sel_led=%0d", i, sel_led);
    end
  endtask

  task automatic test_digit_wrap;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // cursor 3 -> 2
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({led_three, led_two, led_one, led_zero, sel_led} !== {3'd0, 3'd7, 3'd0, 3'd1, 2'd2}) begin
      errors++;
      $display("FAIL digit_wrap: got %h expected %h", {led_three, led_two, led_one, led_zero, sel_led},
               {3'd0, 3'd7, 3'd0, 3'd1, 2'd2});
    end else $display("ok digit_wrap led_two=%0d", led_two);
  endtask

  task automatic test_conflict;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (led_two !== 3'd7) begin
      errors++;
      $display("FAIL conflict_updown: led_two got %0d expected 7", led_two);
    end else $display("ok conflict_updown");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sel_led !== 2'd2) begin
      errors++;
      $display("FAIL conflict_leftright: sel_led got %0d expected 2", sel_led);
    end else $display("ok conflict_leftright");
  endtask

  task automatic test_combined;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // cursor 2 -> 1
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({led_one, sel_led, led_two, led_zero} !== {3'd1, 2'd2, 3'd7, 3'd1}) begin
      errors++;
      $display("FAIL combined: led_one=%0d sel_led=%0d led_two=%0d led_zero=%0d expected 1 2 7 1",
               led_one, sel_led, led_two, led_zero);
    end else $display("ok combined led_one=%0d sel_led=%0d", led_one, sel_led);
  endtask

  task automatic test_freeze;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'((i + 1) % 2), 1'b0);
      checks++;
      if ({led_three, led_two, led_one, led_zero, sel_led} !== {3'd0, 3'd7, 3'd1, 3'd1, 2'd2}) begin
        errors++;
        $display("FAIL freeze[%0d]: got %h expected %h", i, {led_three, led_two, led_one, led_zero, sel_led},
                 {3'd0, 3'd7, 3'd1, 3'd1, 2'd2});
      end else $display("ok freeze[%0d]", i);
    end
  endtask

  task automatic test_back_to_back;
    // First enabled cycle after the freeze steps immediately.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sel_led !== 2'd3) begin
      errors++;
      $display("FAIL resume: sel_led got %0d expected 3", sel_led);
    end else $display("ok resume sel_led=%0d", sel_led);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sel_led, led_zero} !== {2'd0, 3'd2}) begin
      errors++;
      $display("FAIL back_to_back: sel_led=%0d led_zero=%0d expected 0 2", sel_led, led_zero);
    end else $display("ok back_to_back led_zero=%0d", led_zero);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // led_zero 2 -> 1
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // led_zero 1 -> 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // led_zero 0 -> 7
    checks++;
    if (led_zero !== 3'd7) begin
      errors++;
      $display("FAIL down_run: led_zero got %0d expected 7", led_zero);
    end else $display("ok down_run led_zero=%0d", led_zero);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({led_three, led_two, led_one, led_zero, sel_led} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h expected 0000", {led_three, led_two, led_one, led_zero, sel_led});
    end else $display("ok mid_reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({led_zero, sel_led} !== {3'd1, 2'd0}) begin
      errors++;
      $display("FAIL post_reset: led_zero=%0d sel_led=%0d expected 1 0", led_zero, sel_led);
    end else $display("ok post_reset led_zero=%0d", led_zero);
  endtask

  initial begin
    #2;
    test_reset();
    test_up_run();
    test_sel_wrap();
    test_digit_wrap();
    test_conflict();
    test_combined();
    test_freeze();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
